// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads program memory combinationally and buffers words in a 2-entry queue.
// Optional sequential-wrap trap enabled by defining INSTR_FETCH_WRAP_TRAP_EN.
module instr_fetch_queue #(
    parameter int                ADDR_W   = 6,
    parameter int                INS_W    = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INS_W-1:0]  NOP_INS  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [INS_W-1:0]  pm_ins,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              wrap_trap
);

    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [INS_W-1:0]  q_ins [2];
    logic [ADDR_W-1:0] q_pc  [2];
    logic              halted;
    logic              pop;
    logic              fetch;

    assign pm_addr   = pc;
    assign ins_valid = (count != 2'd0);
    assign ins_out   = ins_valid ? q_ins[rd_ptr] : NOP_INS;
    assign ins_pc    = ins_valid ? q_pc[rd_ptr]  : '0;

    // A pop frees a slot in the same cycle, so a full queue keeps streaming.
    assign pop   = ins_valid & ins_ready;
    assign fetch = run & ~halted & ~jmp_en & ((count != 2'd2) | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (jmp_en) begin
            // Redirect flushes the queue; any concurrent pop is absorbed.
            pc     <= jmp_addr;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (fetch) begin
                pc <= pc + ADDR_W'(1);
            end
            wr_ptr <= wr_ptr ^ fetch;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count + 2'(fetch) - 2'(pop);
        end
    end

    // Queue storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (fetch) begin
            q_ins[wr_ptr] <= pm_ins;
            q_pc[wr_ptr]  <= pc;
        end
    end

`ifdef INSTR_FETCH_WRAP_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst || jmp_en) begin
            halted <= 1'b0;
        end else if (fetch && (pc == {ADDR_W{1'b1}})) begin
            halted <= 1'b1;
        end
    end
    assign wrap_trap = halted;
`else
    assign halted    = 1'b0;
    assign wrap_trap = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then randomized traffic, checked against a queue-based model.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [5:0]  pm_addr;
    logic [12:0] pm_ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [12:0] ins_out;
    logic [5:0]  ins_pc;
    logic        jmp_en;
    logic [5:0]  jmp_addr;
    logic        wrap_trap;

    logic [12:0] pm [64];
    assign pm_ins = pm[pm_addr];

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .pm_addr   (pm_addr),
        .pm_ins    (pm_ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_out   (ins_out),
        .ins_pc    (ins_pc),
        .jmp_en    (jmp_en),
        .jmp_addr  (jmp_addr),
        .wrap_trap (wrap_trap)
    );

    typedef struct packed {
        logic [5:0]  pc;
        logic [12:0] ins;
    } entry_t;

    entry_t m_q[$];
    int     m_pc     = 0;
    bit     m_halted = 1'b0;
    int     checks   = 0;
    int     errors   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the queue is a plain list of {pc, word}; rules applied in order of priority.
    task automatic model_step(input bit r, input bit ru, input bit rd, input bit j, input int ja);
        bit p;
        bit f;
        if (r) begin
            m_q.delete();
            m_pc     = 0;
            m_halted = 1'b0;
        end else if (j) begin
            m_q.delete();
            m_pc     = ja;
            m_halted = 1'b0;
        end else begin
            p = (m_q.size() > 0) && rd;
            f = ru && !m_halted && ((m_q.size() < 2) || p);
            if (p) void'(m_q.pop_front());
            if (f) begin
                m_q.push_back('{pc: 6'(m_pc), ins: pm[m_pc]});
`ifdef INSTR_FETCH_WRAP_TRAP_EN
                if (m_pc == 63) m_halted = 1'b1;
`endif
                m_pc = (m_pc + 1) % 64;
            end
        end
    endtask

    task automatic check_all();
        bit v;
        v = (m_q.size() != 0);
        chk("pm_addr", 32'(pm_addr), 32'(m_pc));
        chk("ins_valid", 32'(ins_valid), 32'(v));
        chk("ins_out", 32'(ins_out), v ? 32'(m_q[0].ins) : 32'd0);
        chk("ins_pc", 32'(ins_pc), v ? 32'(m_q[0].pc) : 32'd0);
        chk("wrap_trap", 32'(wrap_trap), 32'(m_halted));
    endtask

    // Drive one cycle of inputs, advance the model, and check after the edge.
    task automatic cyc(input bit r, input bit ru, input bit rd, input bit j, input int ja);
        rst       = r;
        run       = ru;
        ins_ready = rd;
        jmp_en    = j;
        jmp_addr  = 6'(ja);
        model_step(r, ru, rd, j, ja);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) pm[i] = 13'($urandom);

        // Reset and straight-line streaming.
        cyc(1, 0, 0, 0, 0);
        chk("reset_valid", 32'(ins_valid), 32'd0);
        chk("reset_out", 32'(ins_out), 32'd0);
        chk("reset_addr", 32'(pm_addr), 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);

        // Back-pressure fills the queue, then drains without gaps.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
        chk("full_addr_stuck", 32'(pm_addr), 32'd2);
        chk("full_head", 32'(ins_out), 32'(pm[0]));
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);

        // Redirect while full.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 44);
        chk("jmp_flush_valid", 32'(ins_valid), 32'd0);
        chk("jmp_addr_out", 32'(pm_addr), 32'd44);
        cyc(0, 1, 0, 0, 0);
        chk("jmp_target_pc", 32'(ins_pc), 32'd44);
        chk("jmp_target_ins", 32'(ins_out), 32'(pm[44]));

        // Jump chain 42 -> 44 -> 43 -> 45, pulsing when the jump word is at the head.
        cyc(0, 1, 1, 1, 42);
        cyc(0, 1, 1, 1, 44);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 43);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 45);
        cyc(0, 1, 1, 0, 0);
        chk("chain_final_pc", 32'(ins_pc), 32'd45);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 7);
        cyc(0, 1, 1, 0, 0);
        chk("last_jump_wins", 32'(ins_pc), 32'd7);

        // Sequential run across the top of the address space.
        cyc(0, 1, 1, 1, 62);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 0);

        // Freeze with two queued: drain only; then reset with a full queue; frozen jump.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 30);
        chk("rst_prio_valid", 32'(ins_valid), 32'd0);
        chk("rst_prio_addr", 32'(pm_addr), 32'd0);
        cyc(0, 0, 0, 1, 20);
        chk("frozen_jmp_addr", 32'(pm_addr), 32'd20);

        // Randomized traffic; targets biased toward the wrap region.
        for (int i = 0; i < 3000; i++) begin
            int ja;
            ja = ($urandom_range(1, 0) == 1) ? int'($urandom_range(63, 58)) : int'($urandom_range(63, 0));
            cyc($urandom_range(99, 0) == 0,
                $urandom_range(99, 0) < 85,
                $urandom_range(99, 0) < 70,
                $urandom_range(11, 0) == 0,
                ja);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
